timer_bank: RTL



---
 rtl/timer_bank.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/timer_bank.sv
// Multi-channel programmable timer with a shared prescaler.
// Ports: clk, rst (sync, active-high), wr_en/addr/wdata register
// write bus, rdata combinational read data, irq_vec per-channel
// interrupt (pending & irq_en), timer_interrupt OR of irq_vec.
module timer_bank #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              timer_interrupt
);

    localparam logic [4:0] NCH = 5'(NUM_CH);

    logic [NUM_CH-1:0]  en_q, en_d;
    logic [NUM_CH-1:0]  mode_q, mode_d;
    logic [NUM_CH-1:0]  ien_q, ien_d;
    logic [NUM_CH-1:0]  pend_q, pend_d;
    logic [WIDTH-1:0]   cmp_q [NUM_CH];
    logic [WIDTH-1:0]   cmp_d [NUM_CH];
    logic [WIDTH-1:0]   cnt_q [NUM_CH];
    logic [WIDTH-1:0]   cnt_d [NUM_CH];
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;

    logic [3:0] sel_ch;
    logic [1:0] sel_reg;
    logic       ch_hit;
    logic       presc_hit;
    logic       tick;

    logic [NUM_CH-1:0] ctrl_wr;
    logic [NUM_CH-1:0] cmp_wr;
    logic [NUM_CH-1:0] cnt_wr;
    logic [NUM_CH-1:0] stat_wr;
    logic [NUM_CH-1:0] run;

    logic unused_bits;

    assign sel_ch    = addr[7:4];
    assign sel_reg   = addr[3:2];
    assign ch_hit    = ({1'b0, sel_ch} < NCH);
    assign presc_hit = ({1'b0, sel_ch} == NCH) && (sel_reg == 2'd0);
    assign tick      = (pcnt_q == presc_q);

    assign unused_bits = ^{addr[1:0], wdata};

    for (genvar n = 0; n < NUM_CH; n++) begin : g_dec
        logic hit;
        assign hit        = wr_en && ch_hit && (sel_ch == 4'(n));
        assign ctrl_wr[n] = hit && (sel_reg == 2'd0);
        assign cmp_wr[n]  = hit && (sel_reg == 2'd1);
        assign cnt_wr[n]  = hit && (sel_reg == 2'd2);
        assign stat_wr[n] = hit && (sel_reg == 2'd3);
        // A CTRL write clearing en cancels this cycle's tick.
        assign run[n] = tick && en_q[n] && !(ctrl_wr[n] && !wdata[0]);
    end

    always_comb begin
        presc_d = presc_q;
        pcnt_d  = tick ? '0 : pcnt_q + PRESC_W'(1);
        if (wr_en && presc_hit) begin
            presc_d = wdata[PRESC_W-1:0];
            pcnt_d  = '0;
        end
    end

    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        ien_d  = ien_q;
        pend_d = pend_q;
        cmp_d  = cmp_q;
        cnt_d  = cnt_q;
        for (int n = 0; n < NUM_CH; n++) begin
            // Clear first so a same-cycle match set wins.
            if (stat_wr[n] && wdata[0]) begin
                pend_d[n] = 1'b0;
            end
            if (run[n]) begin
                if (cnt_q[n] == cmp_q[n]) begin
                    pend_d[n] = 1'b1;
                    cnt_d[n]  = '0;
                    if (mode_q[n]) begin
                        en_d[n] = 1'b0;
                    end
                end else begin
                    cnt_d[n] = cnt_q[n] + WIDTH'(1);
                end
            end
            // Software writes override the tick update.
            if (ctrl_wr[n]) begin
                en_d[n]   = wdata[0];
                mode_d[n] = wdata[1];
                ien_d[n]  = wdata[2];
            end
            if (cmp_wr[n]) begin
                cmp_d[n] = wdata[WIDTH-1:0];
            end
            if (cnt_wr[n]) begin
                cnt_d[n] = wdata[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= '0;
            mode_q  <= '0;
            ien_q   <= '0;
            pend_q  <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cmp_q[n] <= '0;
                cnt_q[n] <= '0;
            end
        end else begin
            en_q    <= en_d;
            mode_q  <= mode_d;
            ien_q   <= ien_d;
            pend_q  <= pend_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (presc_hit) begin
            rdata = 32'(presc_q);
        end
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_hit && (sel_ch == 4'(n))) begin
                unique case (sel_reg)
                    2'd0: rdata = {29'd0, ien_q[n], mode_q[n], en_q[n]};
                    2'd1: rdata = 32'(cmp_q[n]);
                    2'd2: rdata = 32'(cnt_q[n]);
                    2'd3: rdata = {31'd0, pend_q[n]};
                    default: rdata = '0;
                endcase
            end
        end
    end

    assign irq_vec         = pend_q & ien_q;
    assign timer_interrupt = |irq_vec;

endmodule
